uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
// 8N1 UART with independent TX and RX paths and a receive holding register.
// Define UART_RX_FIFO_EN to replace the holding register with a 4-entry FIFO.
module uart_ctrl #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out,
    output logic       rx_frame_err,
    output logic       rx_overrun
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (data_in_valid) begin
                    tx_shift_d = {1'b1, data_in, 1'b0};
                    tx_bit_d   = '0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == SYM_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign data_in_ready = (tx_state_q == TX_IDLE);
    assign serial_out    = (tx_state_q == TX_IDLE) ? 1'b1 : tx_shift_q[0];

    logic          sync1_q, sync2_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          deliver;
    logic          frame_err_d, frame_err_q;
    logic          overrun_d, overrun_q;

    // Every RX decision uses the synchronized line, never serial_in directly.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_cnt_d    = rx_cnt_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == SMP_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == SYM_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == SYM_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    deliver     = sync2_q;
                    frame_err_d = !sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_shift_q  <= '0;
            rx_bit_q    <= '0;
            rx_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            rx_state_q  <= rx_state_d;
            rx_shift_q  <= rx_shift_d;
            rx_bit_q    <= rx_bit_d;
            rx_cnt_q    <= rx_cnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
    logic [3:0][7:0] fifo_q, fifo_d;
    logic [1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [2:0]      count_q, count_d;
    logic            pop, push;

    always_comb begin
        pop       = (count_q != 3'd0) && data_out_ready;
        push      = deliver && ((count_q != 3'd4) || pop);
        overrun_d = deliver && !push;
        fifo_d    = fifo_q;
        if (push) fifo_d[wr_q] = rx_shift_q;
        wr_d    = wr_q + {1'b0, push};
        rd_d    = rd_q + {1'b0, pop};
        count_d = count_q + {2'b0, push} - {2'b0, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            fifo_q  <= fifo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign data_out       = fifo_q[rd_q];
    assign data_out_valid = (count_q != 3'd0);
`else
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       pop, push;

    // A same-cycle pop frees the register for the incoming byte.
    always_comb begin
        pop       = full_q && data_out_ready;
        push      = deliver && (!full_q || pop);
        overrun_d = deliver && !push;
        hold_d    = push ? rx_shift_q : hold_q;
        full_d    = push ? 1'b1 : (pop ? 1'b0 : full_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign data_out       = hold_q;
    assign data_out_valid = full_q;
`endif
endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_ctrl at default clock and baud settings.
module tb_uart_ctrl;
    localparam int SET = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       serial_in = 1'b1;
    logic       serial_out;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks = 0;
    int passed = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;

    uart_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .serial_in      (serial_in),
        .serial_out     (serial_out),
        .rx_frame_err   (rx_frame_err),
        .rx_overrun     (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] b, input string nm);
        logic [9:0] frame;
        int bad;
        frame = {1'b1, b, 1'b0};
        checks++;
        if (data_in_ready !== 1'b1)
            $display("FAIL %s idle_ready act=%b exp=1", nm, data_in_ready);
        else passed++;
        data_in = b;
        data_in_valid = 1'b1;
        step(1);
        data_in_valid = 1'b0;
        data_in = ~b;
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < SET; c++) begin
                if (serial_out !== frame[i] || data_in_ready !== 1'b0)
                    bad++;
                step(1);
            end
            checks++;
            if (bad !== 0)
                $display("FAIL %s bit%0d bad_cycles=%0d exp_line=%b exp_bad=0",
                         nm, i, bad, frame[i]);
            else passed++;
        end
        checks++;
        if ({data_in_ready, serial_out} !== 2'b11)
            $display("FAIL %s end_idle act=%b exp=11", nm,
                     {data_in_ready, serial_out});
        else passed++;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop,
                            input int stop_len);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            serial_in = bits[i];
            step(SET);
        end
        serial_in = stop;
        step(stop_len);
        serial_in = 1'b1;
        step(SET - stop_len);
    endtask

    task automatic pop_one();
        data_out_ready = 1'b1;
        step(1);
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        checks++;
        if ({serial_out, data_in_ready, data_out_valid,
             rx_frame_err, rx_overrun} !== 5'b11000)
            $display("FAIL reset_flags act=%b exp=11000",
                     {serial_out, data_in_ready, data_out_valid,
                      rx_frame_err, rx_overrun});
        else passed++;
        checks++;
        if (data_out !== 8'h00)
            $display("FAIL reset_data act=%h exp=00", data_out);
        else passed++;
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_tx();
        tx_frame(8'hA5, "tx_a5");
    endtask

    task automatic test_rx();
        rx_frame(8'h3C, 1'b1, SET);
        checks++;
        if ({data_out_valid, data_out} !== {1'b1, 8'h3C})
            $display("FAIL rx_3c act=%b/%h exp=1/3c", data_out_valid, data_out);
        else passed++;
        pop_one();
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL rx_pop act=%b exp=0", data_out_valid);
        else passed++;
    endtask

    task automatic test_glitch();
        int f0, o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        serial_in = 1'b0;
        step(100);
        serial_in = 1'b1;
        step(600);
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL glitch_valid act=%b exp=0", data_out_valid);
        else passed++;
        checks++;
        if ((ferr_cnt - f0) !== 0 || (ovr_cnt - o0) !== 0)
            $display("FAIL glitch_pulses ferr=%0d ovr=%0d exp=0/0",
                     ferr_cnt - f0, ovr_cnt - o0);
        else passed++;
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        rx_frame(8'h55, 1'b0, SET / 2 + 20);
        step(600);
        checks++;
        if ((ferr_cnt - f0) !== 1)
            $display("FAIL ferr_pulses act=%0d exp=1", ferr_cnt - f0);
        else passed++;
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL ferr_valid act=%b exp=0", data_out_valid);
        else passed++;
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        o0 = ovr_cnt;
`ifdef UART_RX_FIFO_EN
        for (int k = 0; k < 4; k++) rx_frame(exp_b[k], 1'b1, SET);
        checks++;
        if ((ovr_cnt - o0) !== 0)
            $display("FAIL fifo_no_ovr act=%0d exp=0", ovr_cnt - o0);
        else passed++;
        rx_frame(exp_b[4], 1'b1, SET);
        checks++;
        if ((ovr_cnt - o0) !== 1)
            $display("FAIL fifo_ovr act=%0d exp=1", ovr_cnt - o0);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({data_out_valid, data_out} !== {1'b1, exp_b[k]})
                $display("FAIL fifo_rd%0d act=%b/%h exp=1/%h", k,
                         data_out_valid, data_out, exp_b[k]);
            else passed++;
            pop_one();
        end
`else
        rx_frame(exp_b[0], 1'b1, SET);
        rx_frame(exp_b[1], 1'b1, SET);
        checks++;
        if ((ovr_cnt - o0) !== 1)
            $display("FAIL ovr_pulses act=%0d exp=1", ovr_cnt - o0);
        else passed++;
        checks++;
        if ({data_out_valid, data_out} !== {1'b1, 8'h11})
            $display("FAIL ovr_keep act=%b/%h exp=1/11",
                     data_out_valid, data_out);
        else passed++;
        pop_one();
`endif
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL ovr_drained act=%b exp=0", data_out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_tx();
        rx_frame(8'h5A, 1'b1, SET);
        checks++;
        if ({data_out_valid, data_out} !== {1'b1, 8'h5A})
            $display("FAIL rst_pre_rx act=%b/%h exp=1/5a",
                     data_out_valid, data_out);
        else passed++;
        data_in = 8'hFF;
        data_in_valid = 1'b1;
        step(1);
        data_in_valid = 1'b0;
        step(3 * SET + 50);
        checks++;
        if (data_in_ready !== 1'b0)
            $display("FAIL rst_pre_busy act=%b exp=0", data_in_ready);
        else passed++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({serial_out, data_in_ready, data_out_valid} !== 3'b110)
            $display("FAIL rst_mid_flags act=%b exp=110",
                     {serial_out, data_in_ready, data_out_valid});
        else passed++;
        checks++;
        if (data_out !== 8'h00)
            $display("FAIL rst_mid_data act=%h exp=00", data_out);
        else passed++;
        step(1);
        rst = 1'b1;
        step(2);
        tx_frame(8'h81, "tx_81");
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
